// File: rtl/clock_scale_pkg.sv
// clock_scale_pkg: shared types and constants for the clock scale bank.
// Divider mode enum, channel-count limit and channel-index width.
package clock_scale_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_t;

  localparam int MAX_CHANNELS = 16;
  localparam int CH_W         = 4;

endpackage

// File: rtl/clock_scale_bank_if.sv
// clock_scale_bank_if: configuration write bus for the clock scale bank.
// cfg_we strobe, cfg_ch index, cfg_div divide value, cfg_mode.
interface clock_scale_bank_if #(
  parameter int WIDTH = 12
);
  import clock_scale_pkg::*;

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [WIDTH-1:0] cfg_div;
  mode_t            cfg_mode;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_div,
    output cfg_mode
  );

  modport slave (
    input cfg_we,
    input cfg_ch,
    input cfg_div,
    input cfg_mode
  );

endinterface

// File: rtl/clock_scale_channel.sv
// clock_scale_channel: one divider with shadow config and glitch-free apply.
// Ports: clk, rst, en, sync, we/wdiv/wmode (staged write), out, pending.
module clock_scale_channel
  import clock_scale_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int RESET_DIV = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             we,
  input  logic [WIDTH-1:0] wdiv,
  input  mode_t            wmode,
  output logic             out,
  output logic             pending
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] sdiv_q, sdiv_d;
  mode_t            mode_q, mode_d;
  mode_t            smode_q, smode_d;
  logic             pend_q, pend_d;
  logic             out_q, out_d;
  logic             wrap;

  assign wrap = (cnt_q == div_q);

  always_comb begin
    cnt_d   = cnt_q;
    div_d   = div_q;
    sdiv_d  = sdiv_q;
    mode_d  = mode_q;
    smode_d = smode_q;
    pend_d  = pend_q;
    out_d   = out_q;

    if (sync || !en) begin
      cnt_d = '0;
      out_d = 1'b0;
      if (pend_q) begin
        div_d  = sdiv_q;
        mode_d = smode_q;
        pend_d = 1'b0;
      end
    end else if (wrap) begin
      cnt_d = '0;
      // A mode switch restarts the output low.
      if (pend_q && (smode_q != mode_q))
        out_d = 1'b0;
      else if (mode_q == MODE_TOGGLE)
        out_d = ~out_q;
      else
        out_d = 1'b1;
      if (pend_q) begin
        div_d  = sdiv_q;
        mode_d = smode_q;
        pend_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (mode_q == MODE_PULSE)
        out_d = 1'b0;
    end

    // A write lands after any apply above.
    if (we) begin
      sdiv_d  = wdiv;
      smode_d = wmode;
      pend_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      div_q   <= WIDTH'(RESET_DIV);
      sdiv_q  <= WIDTH'(RESET_DIV);
      mode_q  <= MODE_TOGGLE;
      smode_q <= MODE_TOGGLE;
      pend_q  <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sdiv_q  <= sdiv_d;
      mode_q  <= mode_d;
      smode_q <= smode_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
    end
  end

  assign out     = out_q;
  assign pending = pend_q;

endmodule

// File: rtl/clock_scale_bank.sv
// clock_scale_bank: CHANNELS programmable clock/tick dividers.
// Ports: clk, rst, ch_en, sync, cfg (write bus), clk_out, pending.
module clock_scale_bank
  import clock_scale_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 12,
  parameter int RESET_DIV = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                sync,
  clock_scale_bank_if.slave   cfg,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] pending
);

  // Indices at or above CHANNELS match no strobe.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic we;

    assign we = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));

    clock_scale_channel #(
      .WIDTH     (WIDTH),
      .RESET_DIV (RESET_DIV)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (ch_en[i]),
      .sync    (sync),
      .we      (we),
      .wdiv    (cfg.cfg_div),
      .wmode   (cfg.cfg_mode),
      .out     (clk_out[i]),
      .pending (pending[i])
    );
  end

endmodule

// File: tb/tb_clock_scale_bank.sv
// tb_clock_scale_bank: directed bench with an expectation scoreboard.
// Expected per-cycle outputs are queued as stimulus is driven.
module tb_clock_scale_bank;
  import clock_scale_pkg::*;

  localparam int CH = 4;
  localparam int W  = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] ch_en;
  logic          sync;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] pending;

  clock_scale_bank_if #(.WIDTH(W)) cfg ();

  clock_scale_bank #(
    .CHANNELS  (CH),
    .WIDTH     (W),
    .RESET_DIV (0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ch_en   (ch_en),
    .sync    (sync),
    .cfg     (cfg),
    .clk_out (clk_out),
    .pending (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    string    tag;
    logic [3:0] om;
    logic [3:0] oe;
    logic [3:0] pm;
    logic [3:0] pe;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   n = 0;

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push(string tag, logic [3:0] om, logic [3:0] oe,
                      logic [3:0] pm, logic [3:0] pe);
    exp_t e;
    e.tag = tag;
    e.om  = om;
    e.oe  = oe;
    e.pm  = pm;
    e.pe  = pe;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    n++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.om != 4'h0)
        chk({e.tag, ".out"}, clk_out & e.om, e.oe);
      if (e.pm != 4'h0)
        chk({e.tag, ".pend"}, pending & e.pm, e.pe);
    end
  endtask

  task automatic wr(int ch, int d, mode_t m);
    cfg.cfg_we   = 1'b1;
    cfg.cfg_ch   = 4'(ch);
    cfg.cfg_div  = W'(d);
    cfg.cfg_mode = m;
  endtask

  function automatic logic [3:0] b(int ch, bit v);
    logic [3:0] r;
    r     = '0;
    r[ch] = v;
    return r;
  endfunction

  // Output level given the list of ticks on which it toggles.
  function automatic bit lvl(int j, int pts[$]);
    bit v;
    v = 1'b0;
    foreach (pts[k])
      if (pts[k] <= j) v = ~v;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w;
    bit   o;
    int   t0[$];
    int   tc0[$];
    int   ts0[$];
    int   ts1[$];

    ch_en        = '1;
    sync         = 1'b0;
    cfg.cfg_we   = 1'b0;
    cfg.cfg_ch   = '0;
    cfg.cfg_div  = '0;
    cfg.cfg_mode = MODE_TOGGLE;

    repeat (2) @(negedge clk);
    chk("rst_out", clk_out, 4'h0);
    chk("rst_pend", pending, 4'h0);
    rst = 1'b0;
    n   = 0;

    // Reset divide 0: every channel toggles each cycle.
    for (int k = 1; k <= 6; k++) begin
      push("reset_toggle", 4'hF, (k % 2 == 1) ? 4'hF : 4'h0, 4'hF, 4'h0);
      tick();
    end

    // ch1 D=3 toggle: staged at a wrap, applied at the next.
    w = n + 1;
    for (int j = 0; j <= 16; j++) begin
      if (j == 0) wr(1, 3, MODE_TOGGLE);
      else cfg.cfg_we = 1'b0;
      if (j == 0) o = bit'(w % 2);
      else o = bit'((w + 1) % 2) ^ bit'(((j - 1) / 4) % 2);
      push("toggle_d3", b(1, 1), b(1, o), b(1, 1), b(1, j == 0));
      tick();
    end

    // ch2 D=4 pulse.
    w = n + 1;
    for (int j = 0; j <= 16; j++) begin
      if (j == 0) wr(2, 4, MODE_PULSE);
      else cfg.cfg_we = 1'b0;
      if (j == 0) o = bit'(w % 2);
      else o = (j >= 6) && ((j - 6) % 5 == 0);
      push("pulse_d4", b(2, 1), b(2, o), b(2, 1), b(2, j == 0));
      tick();
    end

    // ch2 D=0 pulse: held high once applied.
    for (int j = 0; j <= 10; j++) begin
      if (j == 0) wr(2, 0, MODE_PULSE);
      else cfg.cfg_we = 1'b0;
      push("pulse_d0", b(2, 1), b(2, j >= 4), b(2, 1), b(2, j < 4));
      tick();
    end

    // ch0: load D=9 while disabled, then exercise the shadow.
    ch_en[0] = 1'b0;
    wr(0, 9, MODE_TOGGLE);
    push("ch0_dis_wr", 4'h1, 4'h0, 4'h1, 4'h1);
    tick();
    cfg.cfg_we = 1'b0;
    push("ch0_dis_apply", 4'h1, 4'h0, 4'h1, 4'h0);
    tick();
    ch_en[0] = 1'b1;
    t0 = '{9, 19, 22, 25, 28, 31, 37, 43, 49, 53, 57};
    for (int j = 0; j <= 60; j++) begin
      cfg.cfg_we = 1'b0;
      case (j)
        12: wr(0, 2, MODE_TOGGLE);
        28: wr(0, 5, MODE_TOGGLE);
        45: wr(0, 1, MODE_TOGGLE);
        46: wr(0, 3, MODE_TOGGLE);
        default: ;
      endcase
      o = ((j >= 12) && (j <= 18)) || ((j >= 28) && (j <= 30)) ||
          ((j >= 45) && (j <= 48));
      push("shadow_ch0", 4'h1, b(0, lvl(j, t0)), 4'h1, b(0, o));
      tick();
    end
    cfg.cfg_we = 1'b0;

    // ch3: disable mid-count, then re-enable.
    ch_en[3] = 1'b0;
    wr(3, 4, MODE_TOGGLE);
    push("ch3_dis_wr", 4'h8, 4'h0, 4'h8, 4'h8);
    tick();
    cfg.cfg_we = 1'b0;
    push("ch3_dis_apply", 4'h8, 4'h0, 4'h8, 4'h0);
    tick();
    ch_en[3] = 1'b1;
    for (int j = 0; j <= 14; j++) begin
      if (j == 6) ch_en[3] = 1'b0;
      if (j == 8) ch_en[3] = 1'b1;
      o = ((j >= 4) && (j <= 5)) || (j >= 12);
      push("enable_ch3", 4'h8, b(3, o), 4'h8, 4'h0);
      tick();
    end

    // sync with ch0 D=2, ch1 D=5 staged; ch2 written in the sync cycle.
    wr(0, 2, MODE_TOGGLE);
    tick();
    wr(1, 5, MODE_TOGGLE);
    tick();
    ts0 = '{3, 6, 9, 12};
    ts1 = '{6, 12};
    for (int j = 0; j <= 12; j++) begin
      if (j == 0) begin
        sync = 1'b1;
        wr(2, 7, MODE_PULSE);
      end else begin
        sync       = 1'b0;
        cfg.cfg_we = 1'b0;
      end
      o = (j == 1) || (j == 9);
      push("sync", 4'h7,
           b(0, lvl(j, ts0)) | b(1, lvl(j, ts1)) | b(2, o),
           4'hF, (j == 0) ? 4'h4 : 4'h0);
      tick();
    end

    // Out-of-range channel write is ignored.
    wr(15, 9, MODE_PULSE);
    push("ch15_ignored", 4'h0, 4'h0, 4'hF, 4'h0);
    tick();
    wr(3, 9, MODE_TOGGLE);
    push("pend_before_rst", 4'h0, 4'h0, 4'h8, 4'h8);
    tick();
    cfg.cfg_we = 1'b0;

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out", clk_out, 4'h0);
    chk("async_rst_pend", pending, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    n   = 0;
    for (int k = 1; k <= 6; k++) begin
      push("post_rst_div", 4'hF, (k % 2 == 1) ? 4'hF : 4'h0, 4'hF, 4'h0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
